// File: rtl/layer_result_collector_pkg.sv
// Shared definitions for the neural layer stages: state encoding, width helper
// and the saturating requantizer used when narrowing results for the next layer.
package nn_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COLLECT  = 2'd1;
  localparam logic [1:0] ST_FINALIZE = 2'd2;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } requant_t;

  function automatic int acc_width(input int data_width);
    return 2 * data_width;
  endfunction

  // Arithmetic shift, then clamp into a signed data_width range; sat marks a clamp.
  function automatic requant_t sat_requant(input logic signed [63:0] value,
                                           input int shift,
                                           input int data_width);
    requant_t           r;
    logic signed [63:0] s;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    s     = value >>> shift;
    max_v = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_width - 1));
    r.sat   = 1'b0;
    r.value = s;
    if (s > max_v) begin
      r.sat   = 1'b1;
      r.value = max_v;
    end else if (s < min_v) begin
      r.sat   = 1'b1;
      r.value = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/layer_result_collector_buffer.sv
// M-entry activation RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module result_buffer #(
  parameter  int M          = 3,
  parameter  int DATA_WIDTH = 8,
  localparam int AW         = $clog2(M)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]                rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic signed [DATA_WIDTH-1:0] mem [M];
  logic signed [DATA_WIDTH-1:0] rd_data_d;
  logic signed [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Addresses beyond the last entry read as zero.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr} < (AW + 1)'(M)) rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/layer_result_collector.sv
// Gathers M activated results from the upstream layer, requantizes them into a
// readable buffer, tracks the argmax and pulses done when the batch is complete.
module layer_result_collector
  import nn_pkg::*;
#(
  parameter  int M          = 3,
  parameter  int DATA_WIDTH = 8,
  parameter  int SHIFT      = 0,
  localparam int AW         = $clog2(M)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [2*DATA_WIDTH-1:0] in_result,
  input  logic                           in_valid,
  input  logic [AW-1:0]                  rd_addr,
  output logic signed [DATA_WIDTH-1:0]   rd_data,
  output logic [AW-1:0]                  argmax_idx,
  output logic signed [2*DATA_WIDTH-1:0] argmax_val,
  output logic [AW:0]                    count,
  output logic                           sat_flag,
  output logic                           busy,
  output logic                           done
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH);
  localparam int CW        = AW + 1;

  logic [1:0]                  state_q, state_d;
  logic [CW-1:0]               count_q, count_d;
  logic [AW-1:0]               argmax_idx_q, argmax_idx_d;
  logic signed [ACC_WIDTH-1:0] argmax_val_q, argmax_val_d;
  logic                        sat_q, sat_d;
  logic                        accept;
  logic                        last;
  requant_t                    rq;
  logic signed [DATA_WIDTH-1:0] wr_data;

  // Start always wins over a coincident sample.
  assign accept = !start && (state_q == ST_COLLECT) && in_valid;
  assign last   = (count_q == CW'(M - 1));

  always_comb begin
    rq      = sat_requant(64'(in_result), SHIFT, DATA_WIDTH);
    wr_data = DATA_WIDTH'(rq.value);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_COLLECT;
    end else begin
      case (state_q)
        ST_COLLECT:  if (in_valid && last) state_d = ST_FINALIZE;
        ST_FINALIZE: state_d = ST_IDLE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_FINALIZE);
  end

  always_comb begin
    count_d      = count_q;
    argmax_idx_d = argmax_idx_q;
    argmax_val_d = argmax_val_q;
    sat_d        = sat_q;
    if (start) begin
      count_d      = '0;
      argmax_idx_d = '0;
      argmax_val_d = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
      sat_d        = 1'b0;
    end else if (accept) begin
      count_d = count_q + CW'(1);
      sat_d   = sat_q | rq.sat;
      // Strict compare so ties keep the earlier neuron.
      if (count_q == '0 || in_result > argmax_val_q) begin
        argmax_idx_d = count_q[AW-1:0];
        argmax_val_d = in_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      argmax_idx_q <= '0;
      argmax_val_q <= '0;
      sat_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      argmax_idx_q <= argmax_idx_d;
      argmax_val_q <= argmax_val_d;
      sat_q        <= sat_d;
    end
  end

  result_buffer #(
    .M          (M),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign argmax_idx = argmax_idx_q;
  assign argmax_val = argmax_val_q;
  assign count      = count_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_layer_result_collector.sv
// Randomized scoreboard bench for layer_result_collector, two instances with
// SHIFT=0 and SHIFT=2 driven by the same stimulus.
module tb_layer_result_collector;

  localparam int M  = 3;
  localparam int DW = 8;

  typedef struct {
    int idx;
    int val;
    int cnt;
    int sat0;
    int sat2;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic                   in_valid = 1'b0;
  logic signed [2*DW-1:0] in_result = '0;
  logic [1:0]             rd_addr = '0;

  logic signed [DW-1:0]   rd_data0, rd_data2;
  logic [1:0]             argmax_idx0, argmax_idx2;
  logic signed [2*DW-1:0] argmax_val0, argmax_val2;
  logic [2:0]             count0, count2;
  logic                   sat0, sat2, busy0, busy2, done0, done2;

  int total = 0;
  int bad   = 0;

  exp_t exp0_q[$];
  exp_t exp2_q[$];
  int   run_vals[$];
  int   acc_n    = 0;
  bit   running  = 0;
  int   idle_cnt = 0;

  bit   wr_pend = 0;
  int   wr_idx  = 0;
  int   wr_val  = 0;
  int   mem0[M];
  int   mem2[M];
  bit   known[M];
  bit   rd_chk  = 0;
  int   exp_rd0 = 0;
  int   exp_rd2 = 0;

  layer_result_collector #(.M(M), .DATA_WIDTH(DW), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_result(in_result), .in_valid(in_valid),
    .rd_addr(rd_addr), .rd_data(rd_data0), .argmax_idx(argmax_idx0),
    .argmax_val(argmax_val0), .count(count0), .sat_flag(sat0), .busy(busy0), .done(done0));

  layer_result_collector #(.M(M), .DATA_WIDTH(DW), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_result(in_result), .in_valid(in_valid),
    .rd_addr(rd_addr), .rd_data(rd_data2), .argmax_idx(argmax_idx2),
    .argmax_val(argmax_val2), .count(count2), .sat_flag(sat2), .busy(busy2), .done(done2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Floor division by 2^sh, then clamp to the signed DW range.
  function automatic int fdiv(input int v, input int sh);
    int d;
    d = 1 << sh;
    return (v - (((v % d) + d) % d)) / d;
  endfunction

  function automatic int rq(input int v, input int sh);
    int s;
    s = fdiv(v, sh);
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic int sat_of(input int v, input int sh);
    int s;
    s = fdiv(v, sh);
    return (s > 127 || s < -128) ? 1 : 0;
  endfunction

  function automatic exp_t model_run(input int vals[$]);
    exp_t e;
    e.idx = 0; e.val = vals[0]; e.cnt = vals.size(); e.sat0 = 0; e.sat2 = 0;
    foreach (vals[i]) begin
      if (vals[i] > e.val) begin
        e.idx = i;
        e.val = vals[i];
      end
      e.sat0 = e.sat0 | sat_of(vals[i], 0);
      e.sat2 = e.sat2 | sat_of(vals[i], 2);
    end
    return e;
  endfunction

  // Reference buffer contents and expected registered read value.
  always @(posedge clk) begin
    if (rst) begin
      rd_chk  <= 1'b1;
      exp_rd0 <= 0;
      exp_rd2 <= 0;
    end else begin
      if (int'(rd_addr) >= M) begin
        rd_chk  <= 1'b1;
        exp_rd0 <= 0;
        exp_rd2 <= 0;
      end else begin
        rd_chk  <= known[rd_addr];
        exp_rd0 <= mem0[rd_addr];
        exp_rd2 <= mem2[rd_addr];
      end
      if (wr_pend) begin
        mem0[wr_idx]  <= rq(wr_val, 0);
        mem2[wr_idx]  <= rq(wr_val, 2);
        known[wr_idx] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rd_chk) begin
      chk("rd_data_s0", rd_data0, exp_rd0);
      chk("rd_data_s2", rd_data2, exp_rd2);
    end
  end

  always @(negedge clk) begin
    if (done0) begin
      if (exp0_q.size() == 0) chk("unexpected_done_s0", 1, 0);
      else begin
        exp_t e;
        e = exp0_q.pop_front();
        chk("argmax_idx_s0", argmax_idx0, e.idx);
        chk("argmax_val_s0", argmax_val0, e.val);
        chk("count_s0", count0, e.cnt);
        chk("sat_flag_s0", sat0, e.sat0);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (exp2_q.size() == 0) chk("unexpected_done_s2", 1, 0);
      else begin
        exp_t e;
        e = exp2_q.pop_front();
        chk("argmax_idx_s2", argmax_idx2, e.idx);
        chk("argmax_val_s2", argmax_val2, e.val);
        chk("count_s2", count2, e.cnt);
        chk("sat_flag_s2", sat2, e.sat2);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      rd_addr = 2'($urandom_range(0, 3));
    end
  end

  task automatic issue_start(input bit with_valid, input int v);
    @(negedge clk);
    start = 1'b1; in_valid = with_valid; in_result = 16'(v);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    running = 1; acc_n = 0; run_vals.delete();
    chk("start_count", count0, 0);
    chk("start_busy", busy0, 1);
    chk("start_done", done0, 0);
    chk("start_argval", argmax_val0, -32768);
    chk("start_sat", sat0, 0);
  endtask

  task automatic send(input int v);
    bit   acc;
    exp_t e;
    acc = running;
    @(negedge clk);
    in_valid = 1'b1; in_result = 16'(v);
    if (acc) begin
      wr_pend = 1; wr_idx = acc_n; wr_val = v;
      run_vals.push_back(v);
      acc_n++;
      if (acc_n == M) begin
        e = model_run(run_vals);
        exp0_q.push_back(e);
        exp2_q.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; wr_pend = 0;
    if (acc && acc_n == M) begin
      chk("done_pulse_s0", done0, 1);
      chk("done_pulse_s2", done2, 1);
      chk("finalize_busy", busy0, 1);
      running = 0; acc_n = 0; idle_cnt = M;
      @(negedge clk);
      chk("done_low", done0, 0);
      chk("idle_busy", busy0, 0);
    end else if (acc) begin
      chk("collect_count", count0, acc_n);
      chk("collect_done", done0, 0);
    end else begin
      chk("idle_count", count0, idle_cnt);
      chk("idle_done", done0, 0);
    end
  endtask

  task automatic run3(input int a, input int b, input int c);
    issue_start(0, 0);
    send(a);
    send(b);
    send(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    running = 0; acc_n = 0; idle_cnt = 0;
    chk("rst_count", count0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_argidx", argmax_idx0, 0);
    chk("rst_argval", argmax_val0, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_rd_data", rd_data0, 0);
  endtask

  function automatic int rand_val(input int prev);
    logic signed [15:0] t;
    case ($urandom_range(0, 3))
      0: begin t = 16'($urandom); return int'(t); end
      1: return prev;
      default: return $urandom_range(0, 800) - 400;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_count", count0, 0);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_argidx", argmax_idx0, 0);
    chk("reset_argval", argmax_val0, 0);
    chk("reset_sat", sat0, 0);
    chk("reset_rd_data", rd_data0, 0);

    run3(5, 200, -3);
    send(42);
    send(-7);
    run3(7, 7, 2);
    run3(-10, -4, -9);
    run3(300, -600, 12);

    // Restart after two results with a coincident sample that must be dropped.
    issue_start(0, 0);
    send(11);
    send(22);
    issue_start(1, 99);
    send(-1);
    send(50);
    send(50);

    issue_start(0, 0);
    send(1000);
    do_reset();
    repeat (3) send(77);

    for (int r = 0; r < 25; r++) begin
      int v;
      v = $urandom_range(0, 100) - 50;
      issue_start(0, 0);
      for (int k = 0; k < M; k++) begin
        v = rand_val(v);
        send(v);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (4) @(negedge clk);
    chk("pending_done_s0", exp0_q.size(), 0);
    chk("pending_done_s2", exp2_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
